// File: rtl/compare_pkg.sv
// Shared types and constants for the time-shared 8-bit magnitude comparator.
package compare_pkg;

  localparam int SLICES  = 4;
  localparam int SLICE_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Running compare result; exactly one field is set once a chain is seeded.
  typedef struct packed {
    logic eq;
    logic lt;
    logic gt;
  } chain_t;

  localparam chain_t CHAIN_EQ = '{eq: 1'b1, lt: 1'b0, gt: 1'b0};

endpackage

// File: rtl/compare_sequencer_if.sv
// Operand/result handshake bundle between a producer and the compare sequencer.
interface compare_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic       res_eq;
  logic       res_lt;
  logic       res_gt;
  logic [2:0] res_cycles;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, res_eq, res_lt, res_gt, res_cycles
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, res_eq, res_lt, res_gt, res_cycles
  );
endinterface

// File: rtl/compare2_slice.sv
// One 2-bit magnitude compare step folded into the MSB-first EQ/LT/GT chain.
module compare2_slice
  import compare_pkg::*;
(
  input  logic [SLICE_W-1:0] i_a,
  input  logic [SLICE_W-1:0] i_b,
  input  chain_t             i_chain,
  output chain_t             o_chain
);

  // A decided chain is sticky; only an equal-so-far chain looks at this slice.
  always_comb begin
    o_chain = i_chain;
    if (i_chain.eq) begin
      if (i_a > i_b) begin
        o_chain = '{eq: 1'b0, lt: 1'b0, gt: 1'b1};
      end else if (i_a < i_b) begin
        o_chain = '{eq: 1'b0, lt: 1'b1, gt: 1'b0};
      end
    end
  end

endmodule

// File: rtl/compare_sequencer.sv
// 8-bit magnitude compare performed two bits per cycle, MSB first.
//
// state | meaning
// IDLE  | ready for an operand pair
// RUN   | evaluating slice r_idx against the running chain
// DONE  | result held until the consumer takes it
module compare_sequencer
  import compare_pkg::*;
#(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  compare_sequencer_if.slave  bus
);

  state_t     r_state;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [1:0] r_idx;
  logic [2:0] r_cnt;
  chain_t     r_chain;
  logic       r_in_ready;
  logic       r_out_valid;
  chain_t     r_res;
  logic [2:0] r_res_cycles;

  logic [2:0]         w_lsb;
  logic [SLICE_W-1:0] w_slice_a;
  logic [SLICE_W-1:0] w_slice_b;
  chain_t             w_chain;
  logic [2:0]         w_cnt_next;
  logic               w_last;

  assign w_lsb      = {r_idx, 1'b0};
  assign w_slice_a  = r_a[w_lsb +: SLICE_W];
  assign w_slice_b  = r_b[w_lsb +: SLICE_W];
  assign w_cnt_next = r_cnt + 3'd1;
  // idx==0 bounds both the index and the cycle count at SLICES.
  assign w_last     = (r_idx == 2'd0) || (EARLY_EXIT && !w_chain.eq);

  compare2_slice u_slice (
    .i_a     (w_slice_a),
    .i_b     (w_slice_b),
    .i_chain (r_chain),
    .o_chain (w_chain)
  );

  // Sequencer FSM with operand capture and registered handshake/result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_chain      <= '0;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_res        <= '0;
      r_res_cycles <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a        <= bus.a;
            r_b        <= bus.b;
            r_idx      <= 2'(SLICES - 1);
            r_cnt      <= '0;
            r_chain    <= CHAIN_EQ;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_chain <= w_chain;
          r_cnt   <= w_cnt_next;
          if (w_last) begin
            r_res        <= w_chain;
            r_res_cycles <= w_cnt_next;
            r_out_valid  <= 1'b1;
            r_state      <= DONE;
          end else begin
            r_idx <= r_idx - 2'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.res_eq     = r_res.eq;
  assign bus.res_lt     = r_res.lt;
  assign bus.res_gt     = r_res.gt;
  assign bus.res_cycles = r_res_cycles;

endmodule

// File: tb/tb_compare_sequencer.sv
// Random and directed bench for compare_sequencer, both EARLY_EXIT settings run in lockstep.
module tb_compare_sequencer;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  compare_sequencer_if u_if_ee ();
  compare_sequencer_if u_if_full ();

  compare_sequencer #(.EARLY_EXIT(1'b1)) u_dut_ee (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if_ee)
  );

  compare_sequencer #(.EARLY_EXIT(1'b0)) u_dut_full (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if_full)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Golden result {eq, lt, gt, cycles[2:0]} from plain arithmetic on the operands.
  function automatic logic [5:0] model(input logic [7:0] a, input logic [7:0] b, input bit ee);
    logic [2:0] cyc;
    cyc = 3'd4;
    if (ee) begin
      for (int k = 3; k >= 0; k--) begin
        if (((a >> (2 * k)) & 8'h3) != ((b >> (2 * k)) & 8'h3)) begin
          cyc = 3'(4 - k);
          break;
        end
      end
    end
    return {a == b, a < b, a > b, cyc};
  endfunction

  function automatic logic [5:0] res_ee();
    return {u_if_ee.res_eq, u_if_ee.res_lt, u_if_ee.res_gt, u_if_ee.res_cycles};
  endfunction

  function automatic logic [5:0] res_full();
    return {u_if_full.res_eq, u_if_full.res_lt, u_if_full.res_gt, u_if_full.res_cycles};
  endfunction

  task automatic drive_in(input logic v, input logic [7:0] a, input logic [7:0] b);
    u_if_ee.in_valid   = v;
    u_if_ee.a          = a;
    u_if_ee.b          = b;
    u_if_full.in_valid = v;
    u_if_full.a        = a;
    u_if_full.b        = b;
  endtask

  task automatic set_ready(input logic r);
    u_if_ee.out_ready   = r;
    u_if_full.out_ready = r;
  endtask

  // Called at a negedge with both DUTs idle; returns at a negedge with both idle.
  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input int hold);
    logic [5:0] exp_ee;
    logic [5:0] exp_full;
    int lat_ee;
    int lat_full;
    int cyc;
    exp_ee   = model(a, b, 1'b1);
    exp_full = model(a, b, 1'b0);
    lat_ee   = 0;
    lat_full = 0;
    cyc      = 0;
    check("in_ready_ee", 32'(u_if_ee.in_ready), 32'd1);
    check("in_ready_full", 32'(u_if_full.in_ready), 32'd1);
    drive_in(1'b1, a, b);
    @(negedge clk);
    // in_valid stays high with junk operands while busy; it must be ignored.
    drive_in(1'b1, 8'($urandom), 8'($urandom));
    while ((lat_ee == 0 || lat_full == 0) && cyc < 8) begin
      @(negedge clk);
      cyc++;
      drive_in(1'b1, 8'($urandom), 8'($urandom));
      if (u_if_ee.out_valid && lat_ee == 0) lat_ee = cyc;
      if (u_if_full.out_valid && lat_full == 0) lat_full = cyc;
      if (lat_ee != 0) check("res_ee", 32'(res_ee()), 32'(exp_ee));
      if (lat_full != 0) check("res_full", 32'(res_full()), 32'(exp_full));
    end
    check("latency_ee", 32'(lat_ee), 32'(exp_ee[2:0]));
    check("latency_full", 32'(lat_full), 32'd4);
    repeat (hold) begin
      @(negedge clk);
      drive_in(1'b1, 8'($urandom), 8'($urandom));
      check("hold_ee", 32'({u_if_ee.in_ready, u_if_ee.out_valid, res_ee()}), 32'({2'b01, exp_ee}));
      check("hold_full", 32'({u_if_full.in_ready, u_if_full.out_valid, res_full()}), 32'({2'b01, exp_full}));
    end
    set_ready(1'b1);
    drive_in(1'b0, 8'($urandom), 8'($urandom));
    @(negedge clk);
    set_ready(1'b0);
    check("release_ee", 32'({u_if_ee.in_ready, u_if_ee.out_valid}), 32'b10);
    check("release_full", 32'({u_if_full.in_ready, u_if_full.out_valid}), 32'b10);
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    int hold;

    rst_n = 1'b0;
    drive_in(1'b0, 8'h00, 8'h00);
    set_ready(1'b0);
    #12;
    check("reset_ee", 32'({u_if_ee.in_ready, u_if_ee.out_valid, res_ee()}), 32'h80);
    check("reset_full", 32'({u_if_full.in_ready, u_if_full.out_valid, res_full()}), 32'h80);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed corner cases, the first accepted on the first edge after reset release.
    run_txn(8'h80, 8'h7F, 0);
    run_txn(8'h12, 8'h13, 0);
    run_txn(8'hA5, 8'hA5, 0);
    run_txn(8'h00, 8'hFF, 1);
    run_txn(8'hFF, 8'hFE, 5);

    // Reset mid-operation: EARLY_EXIT DUT already DONE, the other still in RUN.
    drive_in(1'b1, 8'h80, 8'h7F);
    @(negedge clk);
    drive_in(1'b0, 8'h00, 8'h00);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_ee", 32'({u_if_ee.in_ready, u_if_ee.out_valid, res_ee()}), 32'h80);
    check("abort_full", 32'({u_if_full.in_ready, u_if_full.out_valid, res_full()}), 32'h80);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("no_result_ee", 32'(u_if_ee.out_valid), 32'd0);
      check("no_result_full", 32'(u_if_full.out_valid), 32'd0);
    end
    run_txn(8'h3C, 8'h3D, 2);

    for (int n = 0; n < 10000; n++) begin
      ra = 8'($urandom);
      case ($urandom_range(0, 2))
        0:       rb = 8'($urandom);
        1:       rb = ra;
        default: rb = ra ^ (8'h01 << $urandom_range(0, 7));
      endcase
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      run_txn(ra, rb, hold);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/compare_sequencer.md
COMPARE_SEQUENCER -- requirements
Module: compare_sequencer

Interface
REQ-001 Parameter EARLY_EXIT, default 1: 1 = stop at the first unequal slice; 0 = always evaluate all four slices.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  operand pair offered.
REQ-005 in_ready  output  1  sequencer can accept an operand pair.
REQ-006 a  input  8  unsigned operand A.
REQ-007 b  input  8  unsigned operand B.
REQ-008 out_valid  output  1  result available.
REQ-009 out_ready  input  1  consumer takes the result.
REQ-010 res_eq  output  1  A == B.
REQ-011 res_lt  output  1  A < B.
REQ-012 res_gt  output  1  A > B.
REQ-013 res_cycles  output  3  number of RUN cycles used, 1..4.

Function
REQ-014 The block SHALL time-share one 2-bit compare slice across a 4-step, MSB-first magnitude compare of a and b.
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE.
REQ-017 out_valid SHALL be 1 only in DONE.
REQ-018 IDLE with in_valid=1: latch a and b, set slice index to 3 (bits 7:6), clear the cycle count, and go to RUN.
REQ-019 Each RUN cycle SHALL evaluate slice[idx] = a[2idx+1:2idx] vs b[2idx+1:2idx], combined with the running EQ/LT/GT chain (initial chain EQ=1, LT=0, GT=0).
REQ-020 Chain rule:
  - if the chain is not EQ, it holds;
  - else slice greater -> GT; slice less -> LT; slice equal -> EQ.
REQ-021 RUN exit (EARLY_EXIT=1): go to DONE when the updated chain is not EQ or idx == 0; otherwise decrement idx and stay in RUN.
REQ-022 RUN exit (EARLY_EXIT=0): go to DONE only when idx == 0.
REQ-023 Latency: out_valid SHALL assert 1..4 cycles after the accepting edge, equal to res_cycles.
REQ-024 Exactly one of res_eq, res_lt, res_gt SHALL be 1 whenever out_valid = 1.
REQ-025 Result outputs SHALL be registered and held stable while out_valid=1 and out_ready=0.
REQ-026 DONE with out_ready=1 SHALL go to IDLE; no new operand is accepted in that same cycle (minimum initiation interval: RUN cycles + 2).
REQ-027 Changes on a, b or in_valid outside IDLE SHALL have no effect on an operation in progress.
REQ-028 res_cycles SHALL not exceed 4; idx SHALL not wrap below 0.

Reset
REQ-029 Asserting rst_n=0 SHALL asynchronously force:
  - state to IDLE;
  - in_ready to 1;
  - out_valid, res_eq, res_lt, res_gt to 0;
  - res_cycles, idx and the latched operands to 0.
REQ-030 Reset in RUN or DONE SHALL abort the operation and produce no result.
REQ-031 The first acceptance after deassertion is allowed on the first rising edge with rst_n=1.

Structure
REQ-032 The shared package (compare_pkg) SHALL hold:
  - the state enum (IDLE, RUN, DONE);
  - constants SLICES=4 and SLICE_W=2.
REQ-033 The slice SHALL be a separate combinational sub-module, compare2_slice: two 2-bit inputs plus the chain in (eq, lt, gt), producing the chain out; no delays in RTL.
REQ-034 The FSM, operand registers, index and counter SHALL be in compare_sequencer; exactly one compare2_slice instance.

Verification
REQ-035 a=8'h80, b=8'h7F, EARLY_EXIT=1 -> GT=1, res_cycles=1, out_valid one cycle after acceptance.
REQ-036 a=8'h12, b=8'h13 -> LT=1, res_cycles=4; a=8'hA5, b=8'hA5 -> EQ=1, res_cycles=4.
REQ-037 a=8'h80, b=8'h7F with EARLY_EXIT=0 -> GT=1, res_cycles=4.
REQ-038 out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready=0; then out_ready=1 -> IDLE next cycle.
REQ-039 rst_n pulsed low during RUN -> immediately IDLE, out_valid=0, no result produced; the next transaction is correct.
REQ-040 10,000 random operand pairs with random out_ready back-pressure -> every result matches the golden A vs B compare.
